sound_scheduler: RTL and testbench
==================================

// Module: sound_scheduler
// PURPOSE
//  Arbitrates one-shot sound requests from N_REQ game-event sources onto the single audio clip player.
//  Latches requests, grants by fixed priority (index 0 highest), pulses play_start with clip_id, then waits for player_done.
//  Enforces a post-clip gap and a play-length watchdog.
//  Sits between game FSM event outputs and the audio player/clip ROM.
// PARAMETERS
//  N_REQ    4     number of requesters; requester i plays clip i
//  CW       2     clip_id width, = $clog2(N_REQ)
//  GAP_CYC  16    idle cycles enforced after each clip ends (>=1)
//  MAX_PLAY 4096  watchdog: max CLK cycles in PLAY before forced stop (>=2)
// PORTS
//  CLK          in   1      system clock, all logic on posedge
//  RST          in   1      asynchronous reset, active-high
//  req          in   N_REQ  one-cycle request pulses, bit i = clip i
//  mute         in   1      level; suppresses and flushes all sound
//  player_done  in   1      one-cycle pulse from player: clip finished
//  play_start   out  1      one-cycle pulse: start clip_id
//  play_stop    out  1      one-cycle pulse: abort current clip
//  clip_id      out  CW     clip being started/played; held through PLAY
//  busy         out  1      high in START, PLAY, GAP
//  pending      out  N_REQ  latched, not yet granted requests
//  timeout_err  out  1      sticky; set on watchdog expiry, cleared only by RST
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0. Reset mid-clip is silent (no play_stop pulse).
//  pending[i] set on req[i]; repeated req while pending merges (no count).
//  States: IDLE, START, PLAY, GAP.
//  IDLE: if !mute and |pending -> latch g = lowest set index into clip_id, clear pending[g], go to START.
//  START (1 cycle): play_start=1; go to PLAY; watchdog cleared to 0.
//  PLAY: watchdog increments each cycle.
//   - player_done -> GAP.
//   - Watchdog reaching MAX_PLAY-1 -> play_stop=1, timeout_err=1, GAP.
//   - player_done and watchdog expiry in the same cycle -> done wins: no stop, no error.
//  GAP: counts GAP_CYC cycles then IDLE; player_done ignored. Latency from IDLE grant to play_start is 1 cycle.
//  mute high: pending forced to 0 every cycle and req ignored. In START or PLAY -> play_stop=1, go to GAP.
//   In GAP, gap continues. clip_id retains its last value.
//  req[g] in the same cycle pending[g] is cleared by a grant -> pending[g] stays 1 (new request wins).
//  play_start and play_stop are never high in the same cycle.
// CONFIGURATION
//  SOUND_PREEMPT_EN defined: in PLAY, if a pending index j < clip_id (strictly higher priority):
//   - play_stop=1 that cycle; clip_id<=j; pending[j] cleared; go to START (no gap).
//   - Preempted clip is dropped, not re-queued.
//   - mute and player_done in the same cycle take precedence over preemption.
//  Not defined: PLAY ends only by done, watchdog or mute; higher-priority requests wait in pending.
// STRUCTURE
//  sound_pkg: state enum (IDLE/START/PLAY/GAP, 2-bit); clip index constants CLIP_* matching requester order.
//  Sub-module sound_prio_enc (combinational, parameter N_REQ):
//   - pending -> valid + lowest-set index.
//   - Also reused for the preemption compare.
//  Watchdog and gap share one counter, width $clog2(max(MAX_PLAY,GAP_CYC))+1.
// TESTING (N_REQ=4, GAP_CYC=4, MAX_PLAY=16)
//  1 req=0100 in IDLE
//    -> play_start 2 cycles later with clip_id=2.
//    -> player_done after 5 cycles -> busy drops exactly 4 cycles later.
//  2 req=1010 in one cycle
//    -> clip 1 plays first; pending=1000 during play.
//    -> clip 3 starts after done+gap.
//  3 No player_done after start
//    -> play_stop at 16th PLAY cycle, timeout_err=1.
//    -> timeout_err stays 1 through next clip until RST.
//  4 mute=1 during PLAY of clip 0 with pending=0110
//    -> play_stop next edge, pending=0000.
//    -> no play_start while mute held.
//  5 req[2] pulse in same cycle clip 2 is granted
//    -> pending[2]=1 afterward; clip 2 plays twice.
//  6 SOUND_PREEMPT_EN, clip 3 playing, req=0001
//    -> play_stop, then play_start clip_id=0 next cycle.
//    -> without macro, clip 0 waits for done+gap.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constants for the sound scheduler: FSM state encoding,
// clip indices in requester order, and the shared counter width helper.
package sound_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StPlay  = 2'd2,
        StGap   = 2'd3
    } sound_state_t;

    localparam int unsigned CLIP_0 = 0;
    localparam int unsigned CLIP_1 = 1;
    localparam int unsigned CLIP_2 = 2;
    localparam int unsigned CLIP_3 = 3;

    // Watchdog and gap timer share one counter sized for the larger of the two.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set
// index (index 0 has the highest priority).
module sound_prio_enc #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CW    = 2
) (
    input  logic [N_REQ-1:0] pending,
    output logic             valid,
    output logic [CW-1:0]    index
);

    always_comb begin
        valid = |pending;
        index = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                index = CW'(i);
            end
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates one-shot sound requests onto a single clip player with a post-clip
// gap and play watchdog. Define SOUND_PREEMPT_EN to let higher-priority requests abort PLAY.
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CW       = 2,
    parameter int unsigned GAP_CYC  = 16,
    parameter int unsigned MAX_PLAY = 4096
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic             mute,
    input  logic             player_done,
    output logic             play_start,
    output logic             play_stop,
    output logic [CW-1:0]    clip_id,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic             timeout_err
);

    localparam int unsigned CNT_W = cnt_width(MAX_PLAY, GAP_CYC);

    sound_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]    clip_q, clip_d;
    logic [N_REQ-1:0] pend_q, pend_d, pend_clr, top_onehot;
    logic             terr_q, terr_d;
    logic             enc_valid;
    logic [CW-1:0]    enc_idx;
    logic             wd_expired;
    logic             gap_done;
    logic             preempt;

    sound_prio_enc #(
        .N_REQ (N_REQ),
        .CW    (CW)
    ) u_prio_enc (
        .pending (pend_q),
        .valid   (enc_valid),
        .index   (enc_idx)
    );

    assign top_onehot = N_REQ'(1) << enc_idx;
    assign wd_expired = (cnt_q == CNT_W'(MAX_PLAY - 1));
    assign gap_done   = (cnt_q == CNT_W'(GAP_CYC - 1));

`ifdef SOUND_PREEMPT_EN
    assign preempt = enc_valid && (enc_idx < clip_q);
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clip_d     = clip_q;
        terr_d     = terr_q;
        pend_clr   = '0;
        play_start = 1'b0;
        play_stop  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!mute && enc_valid) begin
                    clip_d   = enc_idx;
                    pend_clr = top_onehot;
                    state_d  = StStart;
                end
            end
            StStart: begin
                cnt_d = '0;
                // A mute arriving before the clip starts aborts instead of starting.
                if (mute) begin
                    play_stop = 1'b1;
                    state_d   = StGap;
                end else begin
                    play_start = 1'b1;
                    state_d    = StPlay;
                end
            end
            StPlay: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (player_done) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else if (wd_expired) begin
                    play_stop = 1'b1;
                    terr_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StGap;
                end else if (mute) begin
                    play_stop = 1'b1;
                    cnt_d     = '0;
                    state_d   = StGap;
                end else if (preempt) begin
                    play_stop = 1'b1;
                    clip_d    = enc_idx;
                    pend_clr  = top_onehot;
                    state_d   = StStart;
                end
            end
            StGap: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A new request in the grant cycle re-arms the bit being cleared.
        pend_d = mute ? '0 : ((pend_q & ~pend_clr) | req);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            clip_q  <= '0;
            pend_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clip_q  <= clip_d;
            pend_q  <= pend_d;
            terr_q  <= terr_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign pending     = pend_q;
    assign clip_id     = clip_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Randomized scoreboard bench for sound_scheduler: a behavioural model predicts
// start/stop events into a queue that a monitor drains as the DUT emits them.
module tb_sound_scheduler;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned CW       = 2;
    localparam int unsigned GAP_CYC  = 4;
    localparam int unsigned MAX_PLAY = 16;
    localparam int unsigned N_CYC    = 4000;

`ifdef SOUND_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [N_REQ-1:0] req = '0;
    logic             mute = 1'b0;
    logic             player_done = 1'b0;
    logic             play_start;
    logic             play_stop;
    logic [CW-1:0]    clip_id;
    logic             busy;
    logic [N_REQ-1:0] pending;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_start;
        int clip;
    } ev_t;

    ev_t exp_q[$];

    // Model state: mode 0 idle, 1 about to start, 2 playing, 3 gap.
    int       m_mode;
    int       m_clip;
    int       m_age;
    int       m_gap_left;
    bit [3:0] m_pend;
    bit       m_terr;

    sound_scheduler #(
        .N_REQ    (N_REQ),
        .CW       (CW),
        .GAP_CYC  (GAP_CYC),
        .MAX_PLAY (MAX_PLAY)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .mute        (mute),
        .player_done (player_done),
        .play_start  (play_start),
        .play_stop   (play_stop),
        .clip_id     (clip_id),
        .busy        (busy),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_clip     = 0;
        m_age      = 0;
        m_gap_left = 0;
        m_pend     = '0;
        m_terr     = 1'b0;
    endtask

    task automatic push_ev(input bit is_start, input int clip);
        ev_t e;
        e.is_start = is_start;
        e.clip     = clip;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input bit [3:0] r, input bit m, input bit d);
        int clr;
        int nxt;
        clr = -1;
        nxt = m_mode;
        case (m_mode)
            0: begin
                if (!m && m_pend != 0) begin
                    m_clip = lowest(m_pend);
                    clr    = m_clip;
                    nxt    = 1;
                end
            end
            1: begin
                m_age = 0;
                if (m) begin
                    push_ev(1'b0, m_clip);
                    m_gap_left = GAP_CYC;
                    nxt        = 3;
                end else begin
                    push_ev(1'b1, m_clip);
                    nxt = 2;
                end
            end
            2: begin
                m_age++;
                if (d) begin
                    m_gap_left = GAP_CYC;
                    nxt        = 3;
                end else if (m_age == MAX_PLAY) begin
                    push_ev(1'b0, m_clip);
                    m_terr     = 1'b1;
                    m_gap_left = GAP_CYC;
                    nxt        = 3;
                end else if (m) begin
                    push_ev(1'b0, m_clip);
                    m_gap_left = GAP_CYC;
                    nxt        = 3;
                end else if (PREEMPT && m_pend != 0 && lowest(m_pend) < m_clip) begin
                    push_ev(1'b0, m_clip);
                    m_clip = lowest(m_pend);
                    clr    = m_clip;
                    nxt    = 1;
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) nxt = 0;
            end
        endcase
        if (m) begin
            m_pend = '0;
        end else begin
            if (clr >= 0) m_pend[clr] = 1'b0;
            m_pend = m_pend | r;
        end
        m_mode = nxt;
    endtask

    always @(negedge CLK) begin
        if (!RST && (play_start || play_stop)) begin
            if (play_start && play_stop) begin
                check("start_and_stop_together", 1, 0);
            end else if (exp_q.size() == 0) begin
                check(play_start ? "unexpected_start" : "unexpected_stop", 1, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check(e.is_start ? "event_is_start" : "event_is_stop",
                      int'(play_start), int'(e.is_start));
                check("event_clip_id", int'(clip_id), e.clip);
            end
        end
    end

    task automatic check_state();
        check("busy", int'(busy), int'(m_mode != 0));
        check("pending", int'(pending), int'(m_pend));
        check("clip_id", int'(clip_id), m_clip);
        check("timeout_err", int'(timeout_err), int'(m_terr));
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_clip_id", int'(clip_id), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_play_start", int'(play_start), 0);
        check("rst_play_stop", int'(play_stop), 0);
    endtask

    initial begin
        int        mute_left;
        int        done_div;
        bit [3:0]  r;
        bit        d;

        model_reset();
        mute_left = 0;
        done_div  = 6;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs();
        RST = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == N_CYC / 2) begin
                // Asynchronous reset in the middle of activity must be silent.
                check("queue_empty_before_reset", exp_q.size(), 0);
                @(posedge CLK);
                #2;
                RST         = 1'b1;
                req         = '0;
                mute        = 1'b0;
                player_done = 1'b0;
                #1;
                check_reset_outputs();
                model_reset();
                exp_q.delete();
                mute_left = 0;
                repeat (2) @(posedge CLK);
                #1;
                RST = 1'b0;
            end

            @(posedge CLK);
            #1;
            check_state();

            if (cyc % 250 == 0) done_div = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 12);
            if (mute_left > 0) begin
                mute_left--;
            end else if ($urandom_range(0, 70) == 0) begin
                mute_left = $urandom_range(1, 8);
            end
            for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) == 0);
            d = (done_div != 0) && ($urandom_range(0, done_div - 1) == 0);

            req         = r;
            mute        = (mute_left > 0);
            player_done = d;
            model_step(r, mute, d);
        end

        @(posedge CLK);
        #1;
        check_state();
        req         = '0;
        mute        = 1'b0;
        player_done = 1'b0;
        repeat (2) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
